// File: rtl/video_rgb2gray_ctrl.sv
// Valid/ready stream controller around a fixed-latency, non-stallable RGB->gray datapath.
// Define VIDEO_RGB2GRAY_CTRL_STAT_EN to add frame and stall statistics outputs.

module video_rgb2gray_ctrl #(
    parameter int RSIZE      = 4,
    parameter int GSIZE      = 4,
    parameter int BSIZE      = 4,
    parameter int RGB_SIZE   = RSIZE + GSIZE + BSIZE,
    parameter int DP_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_gray_en,
    input  logic                src_vld,
    input  logic                src_sof,
    input  logic [RGB_SIZE-1:0] src_rgb,
    output logic                src_rdy,
    output logic [RGB_SIZE-1:0] dp_src_rgb,
    input  logic [RGB_SIZE-1:0] dp_snk_rgb,
    output logic                snk_vld,
    output logic                snk_sof,
    output logic [RGB_SIZE-1:0] snk_rgb,
    input  logic                snk_rdy,
    output logic                mode_gray
`ifdef VIDEO_RGB2GRAY_CTRL_STAT_EN
    ,
    output logic [15:0]         stat_frame_cnt,
    output logic [15:0]         stat_stall_cnt
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(FIFO_DEPTH + DP_LAT + 1) + 1;

    logic                w_accept;
    logic                w_pix_gray;
    logic                w_push;
    logic                w_pop;
    logic [RGB_SIZE-1:0] w_push_rgb;
    logic [CW-1:0]       w_inflight;
    logic [CW-1:0]       w_credit;

    logic                r_mode_gray;
    logic                r_pipe_vld  [DP_LAT];
    logic                r_pipe_sof  [DP_LAT];
    logic                r_pipe_gray [DP_LAT];
    logic [RGB_SIZE-1:0] r_pipe_rgb  [DP_LAT];

    logic [RGB_SIZE-1:0] r_mem_rgb [FIFO_DEPTH];
    logic                r_mem_sof [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CNTW-1:0]     r_count;

    // Credits cover both buffered and in-flight pixels, so every pipeline exit has a free slot.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < DP_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe_vld[i]);
        end
    end

    assign w_credit   = CW'(r_count) + w_inflight;
    assign src_rdy    = !rst && (w_credit < CW'(FIFO_DEPTH));
    assign w_accept   = src_vld && src_rdy;
    assign dp_src_rgb = src_rgb;
    assign w_pix_gray = src_sof ? cfg_gray_en : r_mode_gray;
    assign mode_gray  = r_mode_gray;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_gray <= 1'b0;
        end else if (w_accept && src_sof) begin
            r_mode_gray <= cfg_gray_en;
        end
    end

    // Side pipeline mirrors the datapath latency; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DP_LAT; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_sof[i]  <= 1'b0;
                r_pipe_gray[i] <= 1'b0;
                r_pipe_rgb[i]  <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_accept;
            r_pipe_sof[0]  <= src_sof;
            r_pipe_gray[0] <= w_pix_gray;
            r_pipe_rgb[0]  <= src_rgb;
            for (int i = 1; i < DP_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_sof[i]  <= r_pipe_sof[i-1];
                r_pipe_gray[i] <= r_pipe_gray[i-1];
                r_pipe_rgb[i]  <= r_pipe_rgb[i-1];
            end
        end
    end

    assign w_push     = r_pipe_vld[DP_LAT-1];
    assign w_push_rgb = r_pipe_gray[DP_LAT-1] ? dp_snk_rgb : r_pipe_rgb[DP_LAT-1];
    assign w_pop      = snk_vld && snk_rdy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rgb[r_wr_ptr] <= w_push_rgb;
            r_mem_sof[r_wr_ptr] <= r_pipe_sof[DP_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // Gate the head entry so stale storage never shows while the FIFO is empty.
    assign snk_vld = (r_count != '0);
    assign snk_sof = snk_vld & r_mem_sof[r_rd_ptr];
    assign snk_rgb = snk_vld ? r_mem_rgb[r_rd_ptr] : '0;

`ifdef VIDEO_RGB2GRAY_CTRL_STAT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && src_sof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (src_vld && !src_rdy && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stat_frame_cnt = r_frame_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule
